// File: rtl/psram_vid_prefetch.sv
// Video-side scanline prefetcher feeding a FIFO from the PSRAM video read port.
// Credit-based: a read is only issued when its result is guaranteed a FIFO slot.
module psram_vid_prefetch #(
    parameter int DEPTH = 16,
    parameter int LEN_W = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   line_start_i,
    input  logic [21:0]            line_addr_i,
    input  logic [LEN_W-1:0]       line_len_i,
    output logic                   rdv_o,
    output logic [21:0]            addr_o,
    input  logic                   memvidbusy_i,
    input  logic [15:0]            dout_i,
    input  logic [15:0]            dout2_i,
    input  logic                   fifo_rd_i,
    output logic [31:0]            fifo_q_o,
    output logic                   fifo_empty_o,
    output logic [$clog2(DEPTH):0] fifo_level_o,
    output logic                   fetch_done_o,
    output logic                   underrun_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW:0] DEPTH_W = DEPTH[LW:0];

    typedef enum logic [1:0] {IDLE, REQ, WAIT_BUSY, WAIT_DATA} state_e;

    state_e            state_q, state_d;
    logic              busy_q;
    logic [21:2]       ptr_q, ptr_d;
    logic [21:0]       addr_q, addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              drop_q, drop_d;
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]     level_q, level_d;
    logic              underrun_q, underrun_d;
    logic [31:0]       mem [DEPTH];

    logic              outstanding;
    logic [LW:0]       free;
    logic              can_issue;
    logic              fall;
    logic              capture;
    logic              push;
    logic              pop;
    logic [1:0]        unused_addr_lsb;

    assign unused_addr_lsb = line_addr_i[1:0];

    assign outstanding = (state_q != IDLE);
    assign free        = DEPTH_W - {1'b0, level_q} - {{LW{1'b0}}, outstanding};
    assign can_issue   = (free != '0) && (remaining_q != '0);
    assign fall        = busy_q && !memvidbusy_i;
    assign capture     = (state_q == WAIT_DATA) && fall;
    assign push        = capture && !drop_q && !line_start_i;
    assign pop         = fifo_rd_i && (level_q != '0) && !line_start_i;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // FSM next-state: one request in flight, wait for busy rise then fall
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (!line_start_i && can_issue) state_d = REQ;
            REQ:       state_d = WAIT_BUSY;
            WAIT_BUSY: if (memvidbusy_i) state_d = WAIT_DATA;
            WAIT_DATA: if (fall) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        rdv_o = (state_q == REQ);
    end

    // Datapath next-state: pointers, counters, drop flag, FIFO bookkeeping
    always_comb begin
        ptr_d       = ptr_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        drop_d      = drop_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        level_d     = level_q;
        underrun_d  = underrun_q;
        if (state_q == IDLE && state_d == REQ) addr_d = {ptr_q, 2'b00};
        if (line_start_i) begin
            ptr_d       = line_addr_i[21:2];
            remaining_d = line_len_i;
            wr_d        = '0;
            rd_d        = '0;
            level_d     = '0;
            underrun_d  = 1'b0;
            // an in-flight read belongs to the old line; a same-cycle capture
            // is simply thrown away
            drop_d      = outstanding && !capture;
        end else begin
            if (capture) drop_d = 1'b0;
            if (push) begin
                ptr_d       = ptr_q + 20'd1;
                remaining_d = remaining_q - {{(LEN_W-1){1'b0}}, 1'b1};
                wr_d        = wr_q + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop) rd_d = rd_q + {{(AW-1){1'b0}}, 1'b1};
            level_d = level_q + {{(LW-1){1'b0}}, push}
                              - {{(LW-1){1'b0}}, pop};
            if (fifo_rd_i && level_q == '0) underrun_d = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy_q      <= 1'b0;
            ptr_q       <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
            drop_q      <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            level_q     <= '0;
            underrun_q  <= 1'b0;
        end else begin
            busy_q      <= memvidbusy_i;
            ptr_q       <= ptr_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            drop_q      <= drop_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            level_q     <= level_d;
            underrun_q  <= underrun_d;
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= {dout2_i, dout_i};
    end

    assign addr_o       = addr_q;
    assign fifo_empty_o = (level_q == '0);
    assign fifo_q_o     = (level_q == '0) ? 32'h0 : mem[rd_q];
    assign fifo_level_o = level_q;
    assign fetch_done_o = (remaining_q == '0);
    assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_psram_vid_prefetch.sv
// Directed bench for psram_vid_prefetch with a simple PSRAM video-port model.
// Expected values are hand-derived from the test scenarios.
module tb_psram_vid_prefetch;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        line_start = 1'b0;
    logic [21:0] line_addr = '0;
    logic [7:0]  line_len = '0;
    logic        rdv;
    logic [21:0] addr;
    logic        memvidbusy = 1'b0;
    logic [15:0] dout = '0;
    logic [15:0] dout2 = '0;
    logic        fifo_rd = 1'b0;
    logic [31:0] fifo_q;
    logic        fifo_empty;
    logic [4:0]  fifo_level;
    logic        fetch_done;
    logic        underrun;

    int          n_chk = 0;
    int          n_fail = 0;
    int          rdv_cnt = 0;
    int          k = 0;
    int          defer = 5;
    logic [21:0] addr_log[$];

    psram_vid_prefetch #(.DEPTH(16), .LEN_W(8)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .line_start_i (line_start),
        .line_addr_i  (line_addr),
        .line_len_i   (line_len),
        .rdv_o        (rdv),
        .addr_o       (addr),
        .memvidbusy_i (memvidbusy),
        .dout_i       (dout),
        .dout2_i      (dout2),
        .fifo_rd_i    (fifo_rd),
        .fifo_q_o     (fifo_q),
        .fifo_empty_o (fifo_empty),
        .fifo_level_o (fifo_level),
        .fetch_done_o (fetch_done),
        .underrun_o   (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Controller model: defer, raise busy 4 cycles, drop busy with data k
    initial begin
        logic [15:0] kk;
        forever begin
            @(negedge clk);
            if (rdv === 1'b1) begin
                rdv_cnt++;
                addr_log.push_back(addr);
                repeat (defer) @(negedge clk);
                memvidbusy = 1'b1;
                repeat (4) @(negedge clk);
                k++;
                kk = k[15:0];
                dout = 16'h1111 * kk;
                dout2 = 16'h2222 * kk;
                memvidbusy = 1'b0;
            end
        end
    end

    task automatic start_line(input logic [21:0] a, input logic [7:0] n);
        line_addr = a;
        line_len = n;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i = 0;
        while (!fetch_done && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(tag, {31'd0, fetch_done}, 32'd1);
    endtask

    task automatic pop(input string tag, input logic [31:0] exp);
        chk(tag, fifo_q, exp);
        fifo_rd = 1'b1;
        @(negedge clk);
        fifo_rd = 1'b0;
    endtask

    initial begin
        int base;
        int k0;
        int i;
        logic [15:0] a;
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        chk("rst_rdv", {31'd0, rdv}, 32'd0);
        chk("rst_addr", {10'd0, addr}, 32'd0);
        chk("rst_empty", {31'd0, fifo_empty}, 32'd1);
        chk("rst_level", {27'd0, fifo_level}, 32'd0);
        chk("rst_q", fifo_q, 32'd0);
        chk("rst_done", {31'd0, fetch_done}, 32'd1);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);

        // pop while empty
        fifo_rd = 1'b1;
        @(negedge clk);
        fifo_rd = 1'b0;
        chk("ur_set", {31'd0, underrun}, 32'd1);
        chk("ur_q_hold", fifo_q, 32'd0);
        chk("ur_level", {27'd0, fifo_level}, 32'd0);

        // basic line
        base = addr_log.size();
        start_line(22'h001002, 8'd3);
        chk("basic_ur_clr", {31'd0, underrun}, 32'd0);
        chk("basic_done0", {31'd0, fetch_done}, 32'd0);
        wait_done("basic_done", 200);
        chk("basic_level", {27'd0, fifo_level}, 32'd3);
        chk("basic_nrdv", addr_log.size() - base, 32'd3);
        if (addr_log.size() >= base + 3) begin
            chk("basic_a0", {10'd0, addr_log[base]}, 32'h001000);
            chk("basic_a1", {10'd0, addr_log[base+1]}, 32'h001004);
            chk("basic_a2", {10'd0, addr_log[base+2]}, 32'h001008);
        end
        pop("basic_q0", 32'h2222_1111);
        pop("basic_q1", 32'h4444_2222);
        pop("basic_q2", 32'h6666_3333);
        chk("basic_empty", {31'd0, fifo_empty}, 32'd1);

        // back-pressure
        base = rdv_cnt;
        start_line(22'h000000, 8'd40);
        repeat (400) @(negedge clk);
        chk("bp_nrdv16", rdv_cnt - base, 32'd16);
        chk("bp_level16", {27'd0, fifo_level}, 32'd16);
        chk("bp_done0", {31'd0, fetch_done}, 32'd0);
        fifo_rd = 1'b1;
        @(negedge clk);
        fifo_rd = 1'b0;
        repeat (60) @(negedge clk);
        chk("bp_nrdv17", rdv_cnt - base, 32'd17);
        chk("bp_level_refill", {27'd0, fifo_level}, 32'd16);
        start_line(22'h000000, 8'd0);
        chk("bp_flush", {27'd0, fifo_level}, 32'd0);
        chk("len0_done", {31'd0, fetch_done}, 32'd1);
        repeat (20) @(negedge clk);
        chk("len0_norq", rdv_cnt - base, 32'd17);

        // deferred grant
        defer = 30;
        base = rdv_cnt;
        start_line(22'h000100, 8'd1);
        repeat (20) @(negedge clk);
        chk("dg_nrdv", rdv_cnt - base, 32'd1);
        chk("dg_nocap", {27'd0, fifo_level}, 32'd0);
        wait_done("dg_done", 100);
        chk("dg_level", {27'd0, fifo_level}, 32'd1);
        chk("dg_nrdv_end", rdv_cnt - base, 32'd1);
        defer = 5;

        // mid-flight restart
        k0 = k;
        base = addr_log.size();
        start_line(22'h100000, 8'd2);
        i = 0;
        while (!memvidbusy && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk("mf_busy", {31'd0, memvidbusy}, 32'd1);
        @(negedge clk);
        start_line(22'h200000, 8'd1);
        chk("mf_flush", {27'd0, fifo_level}, 32'd0);
        wait_done("mf_done", 200);
        chk("mf_level", {27'd0, fifo_level}, 32'd1);
        chk("mf_nrdv", addr_log.size() - base, 32'd2);
        if (addr_log.size() >= base + 2) begin
            chk("mf_a_old", {10'd0, addr_log[base]}, 32'h100000);
            chk("mf_a_new", {10'd0, addr_log[base+1]}, 32'h200000);
        end
        a = 16'(k0 + 2);
        pop("mf_q", {16'h2222 * a, 16'h1111 * a});

        // address wrap
        k0 = k;
        base = addr_log.size();
        start_line(22'h3FFFFE, 8'd2);
        wait_done("wr_done", 200);
        chk("wr_level", {27'd0, fifo_level}, 32'd2);
        if (addr_log.size() >= base + 2) begin
            chk("wr_a0", {10'd0, addr_log[base]}, 32'h3FFFFC);
            chk("wr_a1", {10'd0, addr_log[base+1]}, 32'h000000);
        end else begin
            chk("wr_nrdv", addr_log.size() - base, 32'd2);
        end
        a = 16'(k0 + 1);
        pop("wr_q0", {16'h2222 * a, 16'h1111 * a});

        // reset while waiting for busy
        defer = 20;
        base = rdv_cnt;
        start_line(22'h000010, 8'd1);
        i = 0;
        while (rdv_cnt == base && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk("rs_rdv_seen", rdv_cnt - base, 32'd1);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("rs_rdv", {31'd0, rdv}, 32'd0);
        chk("rs_empty", {31'd0, fifo_empty}, 32'd1);
        chk("rs_done", {31'd0, fetch_done}, 32'd1);
        chk("rs_addr", {10'd0, addr}, 32'd0);
        repeat (50) @(negedge clk);
        chk("rs_nocap", {27'd0, fifo_level}, 32'd0);
        chk("rs_norq", rdv_cnt - base, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
